// File: rtl/input_unit_pkg.sv
// input_unit_pkg: router field widths, info encodings and direction indices shared by the input units.
package input_unit_pkg;
  localparam int ROUTER_INFO_WIDTH = 2;
  localparam int ROUTER_ADDR_WIDTH = 4;
  // Zero is reserved for "no request" so an empty port never looks like UV or broadcast.
  typedef enum logic [ROUTER_INFO_WIDTH-1:0] {
    INFO_NONE      = 2'd0,
    INFO_UNICAST   = 2'd1,
    INFO_UV        = 2'd2,
    INFO_BROADCAST = 2'd3
  } router_info_e;
  typedef enum logic [2:0] {DIR_NW, DIR_NE, DIR_SE, DIR_SW, DIR_LOCAL} router_dir_e;
endpackage

// File: rtl/input_unit_flit_fifo.sv
// flit_fifo: power-of-two circular flit buffer; pointers wrap naturally, storage is never reset.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rdata = mem[rp];
endmodule

// File: rtl/input_unit.sv
// input_unit: per-direction flit buffer with allocator request, grant-driven pop, credit return and sticky overflow.
module input_unit import input_unit_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int INFO_W = ROUTER_INFO_WIDTH,
  parameter int ADDR_W = ROUTER_ADDR_WIDTH,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INFO_W-1:0] in_info,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              credit_out,
  output logic              sa_request,
  output logic [INFO_W-1:0] sa_info,
  output logic [ADDR_W-1:0] sa_addr,
  input  logic              sa_grant,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow
);
  localparam int W = INFO_W + ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] count;
  logic [W-1:0] head;
  logic push, pop;
  assign sa_request = count != '0;
  assign pop = sa_request & sa_grant;
  assign push = in_valid & ((count != CW'(DEPTH)) | pop);
  flit_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk,
    .rst,
    .push,
    .pop,
    .wdata({in_info, in_addr, in_data}),
    .rdata(head),
    .count
  );
  assign {sa_info, sa_addr, out_data} = sa_request ? head : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      credit_out <= pop;
      overflow <= overflow | (in_valid & ~push);
    end
  end
endmodule

// File: tb/tb_input_unit.sv
// tb_input_unit: directed and random checks of input_unit against a queue-based reference model.
module tb_input_unit;
  import input_unit_pkg::*;
  localparam int DEPTH = 4;
  localparam int IW = ROUTER_INFO_WIDTH;
  localparam int AW = ROUTER_ADDR_WIDTH;
  localparam int DW = 32;
  localparam int W = IW + AW + DW;
  typedef logic [W-1:0] flit_t;

  logic clk = 0, rst = 0, in_valid = 0, sa_grant = 0;
  logic [IW-1:0] in_info = '0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic credit_out, sa_request, overflow;
  logic [IW-1:0] sa_info;
  logic [AW-1:0] sa_addr;
  logic [DW-1:0] out_data;

  int checks = 0, failures = 0;
  flit_t q[$];
  logic exp_credit = 0, exp_ovf = 0;
  int model_pops = 0;

  input_unit #(.DEPTH(DEPTH), .INFO_W(IW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_info(in_info), .in_addr(in_addr),
    .in_data(in_data), .credit_out(credit_out), .sa_request(sa_request), .sa_info(sa_info),
    .sa_addr(sa_addr), .sa_grant(sa_grant), .out_data(out_data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic flit_t head();
    return q.size() != 0 ? q[0] : '0;
  endfunction

  // Advance the model by the rules for this cycle's inputs, then let the clock edge happen.
  task automatic tick();
    bit pop, push;
    if (rst) begin
      q.delete();
      exp_credit = 0;
      exp_ovf = 0;
    end else begin
      pop = q.size() != 0 && sa_grant;
      push = in_valid && (q.size() < DEPTH || pop);
      if (pop) begin
        void'(q.pop_front());
        model_pops++;
      end
      if (push) q.push_back({in_info, in_addr, in_data});
      exp_credit = pop;
      if (in_valid && !push) exp_ovf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; sa_grant = 0;
    tick();
    rst = 0;
  endtask

  task automatic drive(input bit v, input logic [IW-1:0] i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = v; in_info = i; in_addr = a; in_data = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sa_request, sa_info, sa_addr, out_data, credit_out, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b info=%h addr=%h data=%h cr=%b ovf=%b exp all zero",
               sa_request, sa_info, sa_addr, out_data, credit_out, overflow);
    end
  endtask

  task automatic test_first_flit();
    do_reset();
    drive(1, 2'd2, 4'd5, 32'hA5);
    checks++;
    if ({sa_request, sa_addr, out_data} !== '0) begin
      failures++;
      $display("FAIL first_no_bypass got req=%b addr=%h data=%h exp 0", sa_request, sa_addr, out_data);
    end
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (sa_request !== 1'b1 || sa_info !== 2'd2 || sa_addr !== 4'd5 || out_data !== 32'hA5) begin
      failures++;
      $display("FAIL first_head got req=%b info=%h addr=%h data=%h exp 1/2/5/a5", sa_request, sa_info, sa_addr, out_data);
    end
  endtask

  task automatic test_drain_order();
    int credits = 0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 2'd1, AW'(k), 32'h100 + k);
      tick();
    end
    drive(0, 0, 0, 0);
    sa_grant = 1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (sa_addr !== AW'(k) || out_data !== 32'h100 + k) begin
        failures++;
        $display("FAIL drain_order k=%0d got addr=%h data=%h exp addr=%h", k, sa_addr, out_data, k);
      end
      tick();
      checks++;
      if (credit_out !== 1'b1) begin
        failures++;
        $display("FAIL drain_credit k=%0d got %b exp 1", k, credit_out);
      end
      credits += credit_out;
    end
    checks++;
    if (sa_request !== 1'b0 || credits != 4) begin
      failures++;
      $display("FAIL drain_empty got req=%b credits=%0d exp 0/4", sa_request, credits);
    end
    tick();
    sa_grant = 0;
    checks++;
    if (credit_out !== 1'b0) begin
      failures++;
      $display("FAIL drain_grant_empty got credit=%b exp 0", credit_out);
    end
  endtask

  task automatic test_overflow();
    int credits = 0, n = 0;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 2'd1, AW'(k), 32'h200 + k);
      tick();
    end
    drive(1, 2'd3, 4'hF, 32'hDEAD);
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || sa_addr !== 4'd1) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b addr=%h exp 1/1", overflow, sa_addr);
    end
    repeat (3) tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
    drive(1, 2'd1, 4'd5, 32'h205);
    sa_grant = 1;
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || credit_out !== 1'b1 || sa_addr !== 4'd2) begin
      failures++;
      $display("FAIL ovf_full_pop got ovf=%b cr=%b addr=%h exp 1/1/2", overflow, credit_out, sa_addr);
    end
    while (sa_request && n < 20) begin
      tick();
      credits += credit_out;
      n++;
    end
    tick();
    credits += credit_out;
    sa_grant = 0;
    checks++;
    if (credits != 4) begin
      failures++;
      $display("FAIL ovf_count got remaining=%0d exp 4", credits);
    end
  endtask

  task automatic test_hold();
    int stable = 1, cr = 0;
    do_reset();
    drive(1, 2'd1, 4'd7, 32'h77);
    tick();
    drive(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (sa_addr !== 4'd7 || sa_request !== 1'b1) stable = 0;
      cr += credit_out;
    end
    checks++;
    if (!stable || cr != 0) begin
      failures++;
      $display("FAIL hold_stable got stable=%0d credits=%0d exp 1/0", stable, cr);
    end
    sa_grant = 1;
    tick();
    sa_grant = 0;
    checks++;
    if (credit_out !== 1'b1 || sa_request !== 1'b0) begin
      failures++;
      $display("FAIL hold_pop got cr=%b req=%b exp 1/0", credit_out, sa_request);
    end
    tick();
    checks++;
    if (credit_out !== 1'b0) begin
      failures++;
      $display("FAIL hold_single_credit got %b exp 0", credit_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 2'd1, AW'(k), 32'h300 + k);
      tick();
    end
    drive(1, 2'd1, 4'd8, 32'h308);
    sa_grant = 1;
    rst = 1;
    tick();
    rst = 0;
    drive(0, 0, 0, 0);
    sa_grant = 0;
    checks++;
    if (sa_request !== 1'b0 || credit_out !== 1'b0 || sa_addr !== '0) begin
      failures++;
      $display("FAIL rst_mid got req=%b cr=%b addr=%h exp 0/0/0", sa_request, credit_out, sa_addr);
    end
    drive(1, 2'd1, 4'd9, 32'h309);
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (sa_addr !== 4'd9 || out_data !== 32'h309 || credit_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_new_first got addr=%h data=%h cr=%b exp 9/309/0", sa_addr, out_data, credit_out);
    end
  endtask

  task automatic test_random();
    int credits, returned = 0, bad = 0;
    flit_t h;
    do_reset();
    model_pops = 0;
    credits = DEPTH;
    for (int c = 0; c < 10000; c++) begin
      if (credits > 0 && $urandom_range(0, 3) != 0) begin
        drive(1, IW'($urandom), AW'($urandom), $urandom);
        credits--;
      end else drive(0, 0, 0, 0);
      sa_grant = $urandom_range(0, 2) != 0;
      tick();
      if (credit_out) begin
        credits++;
        returned++;
      end
      h = head();
      checks++;
      if ({sa_info, sa_addr, out_data} !== h || sa_request !== (q.size() != 0)) begin
        failures++;
        if (bad++ < 5) $display("FAIL rand_head cyc=%0d got req=%b flit=%h exp req=%b flit=%h",
                                c, sa_request, {sa_info, sa_addr, out_data}, q.size() != 0, h);
      end
      checks++;
      if (credit_out !== exp_credit || overflow !== 1'b0) begin
        failures++;
        if (bad++ < 5) $display("FAIL rand_credit_ovf cyc=%0d got cr=%b ovf=%b exp %b/0", c, credit_out, overflow, exp_credit);
      end
    end
    drive(0, 0, 0, 0);
    sa_grant = 0;
    checks++;
    if (returned != model_pops) begin
      failures++;
      $display("FAIL rand_credit_total got %0d exp %0d", returned, model_pops);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_flit();
    test_drain_order();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
